piggy_bank: RTL and testbench

- Credit accumulator directly downstream of the purchase manager in the vending machine.
- Accepts coin-insert pulses and adds them to a stored credit. Receives the one-cycle product pulses (apple/banana/carrot/date) and deducts the matching price.
- On a refund request, returns the remaining credit as a sequence of one-cycle coin-return pulses.
- Drives the 8-bit credit value back to the purchase manager.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/piggy_bank_change_maker.sv | 32 +++
 rtl/piggy_bank.sv | 168 ++++++++++++++++
 tb/tb_piggy_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine constants: coin values, default prices and the credit FSM states.
// Coin-select width follows PIGGY_BANK_DOLLAR_EN (dollar coin present only when defined).
package vend_pkg;

  localparam int unsigned COIN_NICKEL  = 5;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_QUARTER = 25;
  localparam int unsigned COIN_DOLLAR  = 100;

  localparam int unsigned DEF_PRICE_APPLE  = 75;
  localparam int unsigned DEF_PRICE_BANANA = 20;
  localparam int unsigned DEF_PRICE_CARROT = 30;
  localparam int unsigned DEF_PRICE_DATE   = 40;
  localparam int unsigned DEF_MAX_CREDIT   = 250;

  // Bit positions inside the one-hot coin select
  localparam int unsigned SEL_NICKEL  = 0;
  localparam int unsigned SEL_DIME    = 1;
  localparam int unsigned SEL_QUARTER = 2;
`ifdef PIGGY_BANK_DOLLAR_EN
  localparam int unsigned SEL_DOLLAR  = 3;
  localparam int unsigned N_COINS     = 4;
`else
  localparam int unsigned N_COINS     = 3;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    REFUND = 1'b1
  } state_t;

endpackage

// File: rtl/piggy_bank_change_maker.sv
// Combinational largest-coin selector for refunds; includes the dollar coin
// when PIGGY_BANK_DOLLAR_EN is defined.
module change_maker
  import vend_pkg::*;
(
  input  logic [7:0]         remaining,
  output logic [N_COINS-1:0] coin_sel,
  output logic [7:0]         coin_val
);

  always_comb begin
    coin_sel = '0;
    coin_val = '0;
`ifdef PIGGY_BANK_DOLLAR_EN
    if (remaining >= 8'(COIN_DOLLAR)) begin
      coin_sel[SEL_DOLLAR] = 1'b1;
      coin_val             = 8'(COIN_DOLLAR);
    end else
`endif
    if (remaining >= 8'(COIN_QUARTER)) begin
      coin_sel[SEL_QUARTER] = 1'b1;
      coin_val              = 8'(COIN_QUARTER);
    end else if (remaining >= 8'(COIN_DIME)) begin
      coin_sel[SEL_DIME] = 1'b1;
      coin_val           = 8'(COIN_DIME);
    end else if (remaining != '0) begin
      coin_sel[SEL_NICKEL] = 1'b1;
      coin_val             = 8'(COIN_NICKEL);
    end
  end

endmodule

// File: rtl/piggy_bank.sv
// Credit accumulator: adds coins, deducts purchases, refunds credit as coin pulses.
// PIGGY_BANK_DOLLAR_EN adds the dollar input and ret_dollar output.
module piggy_bank
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_APPLE  = DEF_PRICE_APPLE,
  parameter int unsigned PRICE_BANANA = DEF_PRICE_BANANA,
  parameter int unsigned PRICE_CARROT = DEF_PRICE_CARROT,
  parameter int unsigned PRICE_DATE   = DEF_PRICE_DATE,
  parameter int unsigned MAX_CREDIT   = DEF_MAX_CREDIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
`ifdef PIGGY_BANK_DOLLAR_EN
  input  logic       dollar,
  output logic       ret_dollar,
`endif
  input  logic       apple,
  input  logic       banana,
  input  logic       carrot,
  input  logic       date,
  input  logic       refund,
  output logic [7:0] credit,
  output logic       ret_quarter,
  output logic       ret_dime,
  output logic       ret_nickel,
  output logic       coin_reject,
  output logic       buy_err,
  output logic       busy
);

  state_t             state_q, state_d;
  logic [7:0]         credit_q, credit_d;
  logic               ret_quarter_q, ret_quarter_d;
  logic               ret_dime_q, ret_dime_d;
  logic               ret_nickel_q, ret_nickel_d;
  logic               coin_reject_q, coin_reject_d;
  logic               buy_err_q, buy_err_d;
  logic               busy_q, busy_d;
`ifdef PIGGY_BANK_DOLLAR_EN
  logic               ret_dollar_q, ret_dollar_d;
`endif

  logic [3:0]         prod_vec;
  logic               coin_in;
  logic [8:0]         deposit;
  logic [8:0]         price;
  logic [8:0]         price_eff;
  logic [8:0]         sum;
  logic [N_COINS-1:0] coin_sel;
  logic [7:0]         coin_val;

  change_maker u_change_maker (
    .remaining (credit_q),
    .coin_sel  (coin_sel),
    .coin_val  (coin_val)
  );

  assign prod_vec = {apple, banana, carrot, date};

  always_comb begin
    deposit = '0;
    if (nickel)  deposit = deposit + 9'(COIN_NICKEL);
    if (dime)    deposit = deposit + 9'(COIN_DIME);
    if (quarter) deposit = deposit + 9'(COIN_QUARTER);
`ifdef PIGGY_BANK_DOLLAR_EN
    if (dollar)  deposit = deposit + 9'(COIN_DOLLAR);
`endif
    coin_in = (deposit != '0);

    case (prod_vec)
      4'b1000: price = 9'(PRICE_APPLE);
      4'b0100: price = 9'(PRICE_BANANA);
      4'b0010: price = 9'(PRICE_CARROT);
      4'b0001: price = 9'(PRICE_DATE);
      default: price = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    ret_quarter_d = 1'b0;
    ret_dime_d    = 1'b0;
    ret_nickel_d  = 1'b0;
`ifdef PIGGY_BANK_DOLLAR_EN
    ret_dollar_d  = 1'b0;
`endif
    coin_reject_d = 1'b0;
    buy_err_d     = 1'b0;
    price_eff     = price;
    sum           = '0;

    case (state_q)
      IDLE: begin
        // Purchase is judged against the credit before this cycle's deposit
        if ((prod_vec != '0) && (!$onehot(prod_vec) || ({1'b0, credit_q} < price))) begin
          buy_err_d = 1'b1;
          price_eff = '0;
        end
        sum = {1'b0, credit_q} - price_eff + deposit;
        if (sum > 9'(MAX_CREDIT)) begin
          coin_reject_d = 1'b1;
          sum           = {1'b0, credit_q} - price_eff;
        end
        credit_d = sum[7:0];
        if (refund && (credit_d != '0)) state_d = REFUND;
      end
      REFUND: begin
        coin_reject_d = coin_in;
        buy_err_d     = (prod_vec != '0);
        ret_nickel_d  = coin_sel[SEL_NICKEL];
        ret_dime_d    = coin_sel[SEL_DIME];
        ret_quarter_d = coin_sel[SEL_QUARTER];
`ifdef PIGGY_BANK_DOLLAR_EN
        ret_dollar_d  = coin_sel[SEL_DOLLAR];
`endif
        credit_d = credit_q - coin_val;
        if (credit_d == '0) state_d = IDLE;
      end
    endcase

    busy_d = (state_d == REFUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      ret_quarter_q <= 1'b0;
      ret_dime_q    <= 1'b0;
      ret_nickel_q  <= 1'b0;
`ifdef PIGGY_BANK_DOLLAR_EN
      ret_dollar_q  <= 1'b0;
`endif
      coin_reject_q <= 1'b0;
      buy_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      ret_quarter_q <= ret_quarter_d;
      ret_dime_q    <= ret_dime_d;
      ret_nickel_q  <= ret_nickel_d;
`ifdef PIGGY_BANK_DOLLAR_EN
      ret_dollar_q  <= ret_dollar_d;
`endif
      coin_reject_q <= coin_reject_d;
      buy_err_q     <= buy_err_d;
      busy_q        <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign ret_quarter = ret_quarter_q;
  assign ret_dime    = ret_dime_q;
  assign ret_nickel  = ret_nickel_q;
`ifdef PIGGY_BANK_DOLLAR_EN
  assign ret_dollar  = ret_dollar_q;
`endif
  assign coin_reject = coin_reject_q;
  assign buy_err     = buy_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piggy_bank.sv
// Testbench for piggy_bank: directed plan steps plus random traffic against a
// queue-based credit/refund model. Dollar checks run when PIGGY_BANK_DOLLAR_EN is defined.
module tb_piggy_bank;

`ifdef PIGGY_BANK_DOLLAR_EN
  localparam bit DOLLAR_EN = 1'b1;
`else
  localparam bit DOLLAR_EN = 1'b0;
`endif
  localparam int P_APPLE  = 75;
  localparam int P_BANANA = 20;
  localparam int P_CARROT = 30;
  localparam int P_DATE   = 40;
  localparam int MAXC     = 250;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nickel, dime, quarter;
  logic       apple, banana, carrot, date, refund;
  logic [7:0] credit;
  logic       ret_quarter, ret_dime, ret_nickel;
  logic       coin_reject, buy_err, busy;
`ifdef PIGGY_BANK_DOLLAR_EN
  logic       dollar;
  logic       ret_dollar;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int e_credit = 0;
  bit e_busy = 0, e_rq = 0, e_rd = 0, e_rn = 0, e_rdol = 0, e_cr = 0, e_be = 0;
  int coin_q[$];

  always #5 clk = ~clk;

  piggy_bank #(
    .PRICE_APPLE  (P_APPLE),
    .PRICE_BANANA (P_BANANA),
    .PRICE_CARROT (P_CARROT),
    .PRICE_DATE   (P_DATE),
    .MAX_CREDIT   (MAXC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
`ifdef PIGGY_BANK_DOLLAR_EN
    .dollar      (dollar),
    .ret_dollar  (ret_dollar),
`endif
    .apple       (apple),
    .banana      (banana),
    .carrot      (carrot),
    .date        (date),
    .refund      (refund),
    .credit      (credit),
    .ret_quarter (ret_quarter),
    .ret_dime    (ret_dime),
    .ret_nickel  (ret_nickel),
    .coin_reject (coin_reject),
    .buy_err     (buy_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_credit"},  credit,              8'(e_credit));
    check({tag, "_busy"},    {7'd0, busy},        {7'd0, e_busy});
    check({tag, "_retq"},    {7'd0, ret_quarter}, {7'd0, e_rq});
    check({tag, "_retd"},    {7'd0, ret_dime},    {7'd0, e_rd});
    check({tag, "_retn"},    {7'd0, ret_nickel},  {7'd0, e_rn});
    check({tag, "_reject"},  {7'd0, coin_reject}, {7'd0, e_cr});
    check({tag, "_buyerr"},  {7'd0, buy_err},     {7'd0, e_be});
`ifdef PIGGY_BANK_DOLLAR_EN
    check({tag, "_retdol"},  {7'd0, ret_dollar},  {7'd0, e_rdol});
`endif
  endtask

  task automatic model_reset();
    e_credit = 0;
    e_busy = 0; e_rq = 0; e_rd = 0; e_rn = 0; e_rdol = 0; e_cr = 0; e_be = 0;
    coin_q.delete();
  endtask

  // One clock of behaviour from the rules: purchase, deposit/overflow, refund as greedy coin list
  task automatic model_step(input bit n, input bit d, input bit q, input bit dol,
                            input bit a, input bit b, input bit ca, input bit dt, input bit rf);
    int dep, nprod, price, coin, r;
    dep   = (n ? 5 : 0) + (d ? 10 : 0) + (q ? 25 : 0) + ((DOLLAR_EN && dol) ? 100 : 0);
    nprod = int'(a) + int'(b) + int'(ca) + int'(dt);
    e_rq = 0; e_rd = 0; e_rn = 0; e_rdol = 0; e_cr = 0; e_be = 0;
    if (e_busy) begin
      e_cr = (dep != 0);
      e_be = (nprod != 0);
      if (coin_q.size() > 0) begin
        coin = coin_q.pop_front();
        e_credit -= coin;
        e_rdol = (coin == 100);
        e_rq   = (coin == 25);
        e_rd   = (coin == 10);
        e_rn   = (coin == 5);
      end
      e_busy = (e_credit != 0);
    end else begin
      price = a ? P_APPLE : b ? P_BANANA : ca ? P_CARROT : dt ? P_DATE : 0;
      if (nprod > 1 || (nprod == 1 && e_credit < price)) begin
        e_be  = 1;
        price = 0;
      end
      if (e_credit - price + dep > MAXC) begin
        e_cr = (dep != 0);
        dep  = 0;
      end
      e_credit = e_credit - price + dep;
      if (rf && e_credit > 0) begin
        e_busy = 1;
        coin_q.delete();
        r = e_credit;
        if (DOLLAR_EN) begin
          repeat (r / 100) coin_q.push_back(100);
          r = r % 100;
        end
        repeat (r / 25) coin_q.push_back(25);
        r = r % 25;
        repeat (r / 10) coin_q.push_back(10);
        r = r % 10;
        repeat (r / 5) coin_q.push_back(5);
      end
    end
  endtask

  task automatic step(input string tag, input bit n, input bit d, input bit q, input bit dol,
                      input bit a, input bit b, input bit ca, input bit dt, input bit rf);
    @(negedge clk);
    nickel = n; dime = d; quarter = q;
`ifdef PIGGY_BANK_DOLLAR_EN
    dollar = dol;
`endif
    apple = a; banana = b; carrot = ca; date = dt; refund = rf;
    model_step(n, d, q, dol, a, b, ca, dt, rf);
    @(posedge clk);
    #1;
    check_all(tag);
    nickel = 0; dime = 0; quarter = 0;
`ifdef PIGGY_BANK_DOLLAR_EN
    dollar = 0;
`endif
    apple = 0; banana = 0; carrot = 0; date = 0; refund = 0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    nickel = 0; dime = 0; quarter = 0;
    apple = 0; banana = 0; carrot = 0; date = 0; refund = 0;
`ifdef PIGGY_BANK_DOLLAR_EN
    dollar = 0;
`endif
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Three quarters then an apple
    step("q1", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("q2", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("q3", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("apple", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("plan_apple_credit", credit, 8'd0);

    // Insufficient credit, then two products at once
    step("dime10", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("banana_poor", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("plan_banana_err", {7'd0, buy_err}, 8'd1);
    repeat (7) step("fill_q", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("fill_dn", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("plan_credit200", credit, 8'd200);
    step("apple_date", 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // Overflow boundary around MAX_CREDIT
    step("to240", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("ovf_dq", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    check("plan_ovf_reject", {7'd0, coin_reject}, 8'd1);
    step("to250", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("plan_max250", credit, 8'd250);
    step("ovf_n", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Purchase with simultaneous deposit
    step("buy_a1", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("buy_a2", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("buy_a3", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("to40", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("date_q", 0, 0, 1, 0, 0, 0, 0, 1, 0);
    check("plan_date_q", credit, 8'd25);

    // 65c refund with a coin and a carrot arriving mid-refund
    step("to65", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("refund65", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rf_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rf_c2_qc", 0, 0, 1, 0, 0, 0, 1, 0, 1);
    step("rf_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("plan_rf_dime", {7'd0, ret_dime}, 8'd1);
    step("rf_c4", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("plan_rf_end_busy", {7'd0, busy}, 8'd0);
    idle("rf_after");

    // Asynchronous reset on the second refund cycle
    step("re_q1", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("re_q2", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("re_refund", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("re_cyc2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst");

`ifdef PIGGY_BANK_DOLLAR_EN
    step("dol_dime", 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("dol_refund", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("dol_r1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("plan_ret_dollar", {7'd0, ret_dollar}, 8'd1);
    step("dol_r2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("plan_dol_end", credit, 8'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           DOLLAR_EN && ($urandom_range(0, 7) == 0),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0);
    end

    for (int i = 0; i < 30 && e_busy; i++) idle("drain");
    check("drain_busy", {7'd0, busy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
